// File: rtl/eqn_cmp_pkg.sv
// Shared constants and result type for the streaming equality comparator.
package eqn_cmp_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_MATCH_THRESH = 4;

  // Reduced comparison result carried by the second pipeline stage
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_result_t;

endpackage

// File: rtl/eqn_run_counter.sv
// Saturating run counter of consecutive equal results, with synchronous
// clear (priority over counting) and a registered threshold flag.
module eqn_run_counter
  import eqn_cmp_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MATCH_THRESH = DEF_MATCH_THRESH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             xfer,
  input  logic             eq,
  output logic [CNT_W-1:0] cnt,
  output logic             lock
);

  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(MATCH_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_next;

  // Next count: clear wins, then a transferred result bumps or zeroes the run
  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (xfer) begin
      if (!eq) begin
        cnt_next = '0;
      end else if (cnt != CNT_MAX) begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Count and lock are registered together so lock never lags the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      lock <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      lock <= (cnt_next >= THRESH);
    end
  end

endmodule

// File: rtl/eqn_stream_cmp.sv
// Two-stage valid/ready operand comparator with a match-run counter.
// Stage 1 holds the bitwise equality vector, stage 2 the reduced result.
// Optional feature macro: EQN_CMP_MAGNITUDE_EN adds unsigned gt/lt outputs.
module eqn_stream_cmp
  import eqn_cmp_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MATCH_THRESH = DEF_MATCH_THRESH
) (
  input  logic             clk_amisha,
  input  logic             rst_n_amisha,
  input  logic             clr_amisha,
  input  logic             in_valid_amisha,
  output logic             in_ready_amisha,
  input  logic [WIDTH-1:0] a_amisha,
  input  logic [WIDTH-1:0] b_amisha,
  output logic             out_valid_amisha,
  input  logic             out_ready_amisha,
  output logic             eq_amisha,
`ifdef EQN_CMP_MAGNITUDE_EN
  output logic             gt_amisha,
  output logic             lt_amisha,
`endif
  output logic [CNT_W-1:0] run_cnt_amisha,
  output logic             lock_amisha
);

  logic             advance;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_eqv;

  // The whole pipeline moves together whenever the output slot is free
  assign advance         = ~out_valid_amisha | out_ready_amisha;
  assign in_ready_amisha = advance;

  // Stage 1: capture valid bit and per-bit equality vector
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      s1_valid <= 1'b0;
      s1_eqv   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid_amisha;
      s1_eqv   <= ~(a_amisha ^ b_amisha);
    end
  end

`ifdef EQN_CMP_MAGNITUDE_EN
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  cmp_result_t      s2_res;

  // Stage 1 operand copies, needed only for the magnitude compare
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      s1_a <= '0;
      s1_b <= '0;
    end else if (advance) begin
      s1_a <= a_amisha;
      s1_b <= b_amisha;
    end
  end

  // Stage 2: reduce equality and compute unsigned ordering
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      out_valid_amisha <= 1'b0;
      s2_res           <= '0;
    end else if (advance) begin
      out_valid_amisha <= s1_valid;
      s2_res.eq        <= &s1_eqv;
      s2_res.gt        <= (s1_a > s1_b);
      s2_res.lt        <= (s1_a < s1_b);
    end
  end

  assign eq_amisha = s2_res.eq;
  assign gt_amisha = s2_res.gt;
  assign lt_amisha = s2_res.lt;
`else
  logic s2_eq;

  // Stage 2: reduce the equality vector to a single flag
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      out_valid_amisha <= 1'b0;
      s2_eq            <= 1'b0;
    end else if (advance) begin
      out_valid_amisha <= s1_valid;
      s2_eq            <= &s1_eqv;
    end
  end

  assign eq_amisha = s2_eq;
`endif

  eqn_run_counter #(
    .CNT_W        (CNT_W),
    .MATCH_THRESH (MATCH_THRESH)
  ) u_run_counter (
    .clk   (clk_amisha),
    .rst_n (rst_n_amisha),
    .clr   (clr_amisha),
    .xfer  (out_valid_amisha & out_ready_amisha),
    .eq    (eq_amisha),
    .cnt   (run_cnt_amisha),
    .lock  (lock_amisha)
  );

endmodule

// File: tb/tb_eqn_stream_cmp.sv
// Self-checking bench for eqn_stream_cmp: queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
// Honours EQN_CMP_MAGNITUDE_EN to also check gt/lt.
module tb_eqn_stream_cmp;

  localparam int WIDTH        = 8;
  localparam int CNT_W        = 2;
  localparam int MATCH_THRESH = 2;
  localparam int CNT_MAX      = 3;

  localparam int EXP_RUN [8] = '{0, 0, 0, 1, 2, 3, 3, 0};
  localparam int EXP_LOCK[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
  localparam int EXP_VLD [8] = '{0, 0, 1, 1, 1, 1, 1, 0};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready;
  logic             out_valid;
  logic             eq;
  logic             lock;
  logic [CNT_W-1:0] run_cnt;
`ifdef EQN_CMP_MAGNITUDE_EN
  logic             gt;
  logic             lt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  pair_t sb_q[$];
  int    model_run = 0;
  logic  prev_stall = 1'b0;
  logic  prev_eq = 1'b0;

  eqn_stream_cmp #(
    .WIDTH        (WIDTH),
    .CNT_W        (CNT_W),
    .MATCH_THRESH (MATCH_THRESH)
  ) dut (
    .clk_amisha       (clk),
    .rst_n_amisha     (rst_n),
    .clr_amisha       (clr),
    .in_valid_amisha  (in_valid),
    .in_ready_amisha  (in_ready),
    .a_amisha         (a),
    .b_amisha         (b),
    .out_valid_amisha (out_valid),
    .out_ready_amisha (out_ready),
    .eq_amisha        (eq),
`ifdef EQN_CMP_MAGNITUDE_EN
    .gt_amisha        (gt),
    .lt_amisha        (lt),
`endif
    .run_cnt_amisha   (run_cnt),
    .lock_amisha      (lock)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return mid-cycle
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] av,
                               input logic [WIDTH-1:0] bv, input logic rdy,
                               input logic c);
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = av;
    b         = bv;
    out_ready = rdy;
    clr       = c;
    @(negedge clk);
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model: pairs queue in order, each result is judged from its
  // operands, and the run count follows the transfer/clear rules
  always @(negedge clk) begin
    pair_t p;
    logic  exp_eq;
    logic  xfer;
    if (!rst_n) begin
      sb_q.delete();
      model_run  = 0;
      prev_stall = 1'b0;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_run_cnt", run_cnt, 0);
      checkOutput("rst_lock", lock, 0);
      checkOutput("rst_in_ready", in_ready, 1);
    end else begin
      xfer   = 1'b0;
      exp_eq = 1'b0;
      checkOutput("run_cnt", run_cnt, model_run);
      checkOutput("lock", lock, (model_run >= MATCH_THRESH) ? 1 : 0);
      checkOutput("in_ready", in_ready, (out_valid && !out_ready) ? 0 : 1);
      if (prev_stall) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_eq", eq, prev_eq);
      end
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("spurious_result", out_valid, 0);
        end else begin
          p      = sb_q[0];
          exp_eq = (p.a == p.b);
          checkOutput("eq", eq, exp_eq);
`ifdef EQN_CMP_MAGNITUDE_EN
          checkOutput("gt", gt, (p.a > p.b) ? 1 : 0);
          checkOutput("lt", lt, (p.a < p.b) ? 1 : 0);
`endif
          if (out_ready) begin
            void'(sb_q.pop_front());
            xfer = 1'b1;
          end
        end
      end
      if (clr) begin
        model_run = 0;
      end else if (xfer) begin
        model_run = exp_eq ? ((model_run < CNT_MAX) ? model_run + 1 : CNT_MAX) : 0;
      end
      prev_stall = out_valid && !out_ready;
      prev_eq    = eq;
      if (in_valid && in_ready) begin
        p.a = a;
        p.b = b;
        sb_q.push_back(p);
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Single equal pair: latency and first count
    resetDut();
    applyStimulus(1'b1, 8'h5A, 8'h5A, 1'b1, 1'b0);
    checkOutput("t1_c0_valid", out_valid, 0);
    checkOutput("t1_c0_ready", in_ready, 1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("t1_c1_valid", out_valid, 0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("t1_c2_valid", out_valid, 1);
    checkOutput("t1_c2_eq", eq, 1);
`ifdef EQN_CMP_MAGNITUDE_EN
    checkOutput("t1_c2_gt", gt, 0);
    checkOutput("t1_c2_lt", lt, 0);
`endif
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("t1_c3_valid", out_valid, 0);
    checkOutput("t1_c3_run", run_cnt, 1);
    checkOutput("t1_c3_lock", lock, 0);

    // Back-to-back pairs (3,3), (7,2), (1,9)
    resetDut();
    applyStimulus(1'b1, 8'd3, 8'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd7, 8'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd1, 8'd9, 1'b1, 1'b0);
    checkOutput("t2_r0_valid", out_valid, 1);
    checkOutput("t2_r0_eq", eq, 1);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput("t2_r1_valid", out_valid, 1);
    checkOutput("t2_r1_eq", eq, 0);
    checkOutput("t2_r1_run", run_cnt, 1);
`ifdef EQN_CMP_MAGNITUDE_EN
    checkOutput("t2_r1_gt", gt, 1);
    checkOutput("t2_r1_lt", lt, 0);
`endif
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput("t2_r2_valid", out_valid, 1);
    checkOutput("t2_r2_eq", eq, 0);
    checkOutput("t2_r2_run", run_cnt, 0);
`ifdef EQN_CMP_MAGNITUDE_EN
    checkOutput("t2_r2_gt", gt, 0);
    checkOutput("t2_r2_lt", lt, 1);
`endif
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput("t2_end_valid", out_valid, 0);
    checkOutput("t2_end_run", run_cnt, 0);

    // Five-cycle downstream stall with the pipeline full
    resetDut();
    applyStimulus(1'b1, 8'd10, 8'd10, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd20, 8'd21, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 8'd30, 8'd30, 1'b0, 1'b0);
      checkOutput("t3_stall_ready", in_ready, 0);
      checkOutput("t3_stall_valid", out_valid, 1);
      checkOutput("t3_stall_eq", eq, 1);
    end
    applyStimulus(1'b1, 8'd30, 8'd30, 1'b1, 1'b0);
    checkOutput("t3_rel_ready", in_ready, 1);
    checkOutput("t3_rel_eq0", eq, 1);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput("t3_valid1", out_valid, 1);
    checkOutput("t3_eq1", eq, 0);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput("t3_valid2", out_valid, 1);
    checkOutput("t3_eq2", eq, 1);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput("t3_end_valid", out_valid, 0);
    checkOutput("t3_end_run", run_cnt, 1);

    // Saturation at 3, lock at 2, clear with the fifth transfer
    resetDut();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c < 5, WIDTH'(8'h33 + c), WIDTH'(8'h33 + c), 1'b1, c == 6);
      checkOutput($sformatf("t4_c%0d_valid", c), out_valid, EXP_VLD[c]);
      checkOutput($sformatf("t4_c%0d_run", c), run_cnt, EXP_RUN[c]);
      checkOutput($sformatf("t4_c%0d_lock", c), lock, EXP_LOCK[c]);
    end

    // Asynchronous reset with two pairs in flight
    resetDut();
    applyStimulus(1'b1, 8'd5, 8'd5, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd4, 8'd4, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'd6, 8'd6, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("t5_pre_valid", out_valid, 1);
    checkOutput("t5_pre_run", run_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", out_valid, 0);
    checkOutput("t5_rst_run", run_cnt, 0);
    checkOutput("t5_rst_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
      checkOutput("t5_no_stale", out_valid, 0);
    end
    applyStimulus(1'b1, 8'd9, 8'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput("t5_new_valid", out_valid, 1);
    checkOutput("t5_new_eq", eq, 0);
`ifdef EQN_CMP_MAGNITUDE_EN
    checkOutput("t5_new_gt", gt, 1);
`endif
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    checkOutput("t5_end_valid", out_valid, 0);
    checkOutput("t5_end_run", run_cnt, 0);

    checkOutput("drain_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
